// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control sequencer.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // States that hold a memory request open and may wait on mem_ready.
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Bounded-wait counter for memory handshake states; flags the last allowed cycle.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer for a single-ALU, single-memory RISC-V datapath (R-type, lw, sw, beq).
module multicycle_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] OPCode,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ResultSrc,
  output logic       Branch,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  state_t state_q;
  state_t state_d;
  logic   waiting_s;
  logic   expired_s;
  logic   tmr_clear_s;
  logic   tmr_inc_s;

  // Next-state and output decode; reset forces every strobe and select low.
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    AdrSrc      = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    ResultSrc   = RES_ALUOUT;
    Branch      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          MemRead   = 1'b1;
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALU;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_DECODE;
          end else if (expired_s) begin
            mem_timeout = 1'b1;   // retry fetch, PC untouched
            state_d     = S_FETCH;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;   // branch target lands in ALUOut
          ALUSrcB = SRCB_IMM;
          case (OPCode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXEC_R;
            OP_BEQ:       state_d = S_BEQ;
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_IMM;
          case (OPCode)
            OP_LW:   state_d = S_MEMRD;
            OP_SW:   state_d = S_MEMWR;
            default: state_d = S_FETCH;
          endcase
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          AdrSrc  = 1'b1;
          if (mem_ready) begin
            state_d = S_MEMWB;
          end else if (expired_s) begin
            mem_timeout = 1'b1;   // abandon the load
            state_d     = S_FETCH;
          end else begin
            state_d = S_MEMRD;
          end
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          ResultSrc  = RES_MEMDATA;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          AdrSrc   = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else if (expired_s) begin
            mem_timeout = 1'b1;   // abandon the store
            state_d     = S_FETCH;
          end else begin
            state_d = S_MEMWR;
          end
        end
        S_EXEC_R: begin
          ALUSrcA = SRCA_RS1;
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALUOP_FUNCT;
          state_d = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          ResultSrc  = RES_ALUOUT;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        S_BEQ: begin
          ALUSrcA    = SRCA_RS1;
          ALUSrcB    = SRCB_RS2;
          ALUOp      = ALUOP_SUB;
          Branch     = 1'b1;
          ResultSrc  = RES_ALUOUT;
          PCWrite    = Zero;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Timer control: count only while stalled in a memory state; any exit or handshake clears it.
  always_comb begin
    waiting_s   = is_wait_state(state_q) && !reset;
    tmr_inc_s   = waiting_s && !mem_ready && !expired_s;
    tmr_clear_s = !tmr_inc_s;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  mem_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear_s),
    .inc     (tmr_inc_s),
    .expired (expired_s)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: a per-instruction phase model predicts every cycle's outputs.
module tb_multicycle_control_fsm;

  localparam int TMO = 16;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  // Output vector bit masks: {PCWrite,AdrSrc,IRWrite,MemRead,MemWrite,RegWrite,
  //  ALUSrcA[2],ALUSrcB[2],ALUOp[2],ResultSrc[2],Branch,instr_done,illegal_op,mem_timeout}
  localparam logic [17:0] PCW = 18'h20000;
  localparam logic [17:0] ADR = 18'h10000;
  localparam logic [17:0] IRW = 18'h08000;
  localparam logic [17:0] MRD = 18'h04000;
  localparam logic [17:0] MWR = 18'h02000;
  localparam logic [17:0] RGW = 18'h01000;
  localparam logic [17:0] BR  = 18'h00008;
  localparam logic [17:0] DN  = 18'h00004;
  localparam logic [17:0] IL  = 18'h00002;
  localparam logic [17:0] TO  = 18'h00001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] OPCode = 7'd0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, IRWrite, MemRead, MemWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic       Branch, instr_done, illegal_op, mem_timeout;
  logic [17:0] obs;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic        rdy;
    logic [17:0] exp;
    string       tag;
  } cyc_t;
  cyc_t plan[$];

  multicycle_control_fsm #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .OPCode(OPCode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .Branch(Branch), .instr_done(instr_done),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  assign obs = {PCWrite, AdrSrc, IRWrite, MemRead, MemWrite, RegWrite,
                ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Branch, instr_done, illegal_op, mem_timeout};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] sel(input logic [1:0] a, input logic [1:0] b,
                                      input logic [1:0] op, input logic [1:0] rs);
    return {6'b000000, a, b, op, rs, 4'b0000};
  endfunction

  function automatic void push(input logic rdy, input logic [17:0] e, input string t);
    cyc_t c;
    c.rdy = rdy;
    c.exp = e;
    c.tag = t;
    plan.push_back(c);
  endfunction

  // A memory phase: w low cycles then a ready cycle, cut short at TMO cycles by a timeout.
  function automatic bit mem_phase(input logic [17:0] base, input logic [17:0] done_x,
                                   input int w, input string t);
    int n = (w < TMO) ? w + 1 : TMO;
    for (int i = 0; i < n; i++) begin
      if (i == w)            push(1'b1, base | done_x, t);
      else if (i == TMO - 1) push(1'b0, base | TO, {t, "_tmo"});
      else                   push(1'b0, base, t);
    end
    return (w < TMO);
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom % 2);
  endfunction

  // Build the expected cycle sequence for one instruction attempt.
  function automatic void build(input logic [6:0] opc, input logic z, input int fw, input int mw);
    bit ok;
    plan.delete();
    ok = mem_phase(MRD | sel(2'b00, 2'b10, 2'b00, 2'b10), PCW | IRW, fw, "fetch");
    if (ok) begin
      case (opc)
        OPC_LW: begin
          push(rnd_bit(), sel(2'b01, 2'b01, 2'b00, 2'b00), "decode");
          push(rnd_bit(), sel(2'b10, 2'b01, 2'b00, 2'b00), "memadr");
          if (mem_phase(MRD | ADR, 18'h0, mw, "memrd"))
            push(rnd_bit(), RGW | DN | sel(2'b00, 2'b00, 2'b00, 2'b01), "memwb");
        end
        OPC_SW: begin
          push(rnd_bit(), sel(2'b01, 2'b01, 2'b00, 2'b00), "decode");
          push(rnd_bit(), sel(2'b10, 2'b01, 2'b00, 2'b00), "memadr");
          ok = mem_phase(MWR | ADR, DN, mw, "memwr");
        end
        OPC_R: begin
          push(rnd_bit(), sel(2'b01, 2'b01, 2'b00, 2'b00), "decode");
          push(rnd_bit(), sel(2'b10, 2'b00, 2'b10, 2'b00), "exec_r");
          push(rnd_bit(), RGW | DN, "aluwb");
        end
        OPC_BEQ: begin
          push(rnd_bit(), sel(2'b01, 2'b01, 2'b00, 2'b00), "decode");
          push(rnd_bit(), BR | DN | sel(2'b10, 2'b00, 2'b01, 2'b00) | (z ? PCW : 18'h0), "beq");
        end
        default: push(rnd_bit(), IL | sel(2'b01, 2'b01, 2'b00, 2'b00), "illegal");
      endcase
    end
  endfunction

  // Play the plan: called and returns 1 time unit after a rising edge.
  task automatic play();
    foreach (plan[i]) begin
      mem_ready = plan[i].rdy;
      @(negedge clk);
      check_eq(plan[i].tag, 32'(obs), 32'(plan[i].exp));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic z, input int fw, input int mw);
    OPCode = opc;
    Zero   = z;
    build(opc, z, fw, mw);
    play();
  endtask

  function automatic int rnd_wait();
    int r = int'($urandom % 20);
    if (r < 12)      return int'($urandom_range(0, 2));
    else if (r < 17) return int'($urandom_range(3, 6));
    else if (r < 19) return TMO - 1;
    else             return TMO;
  endfunction

  function automatic logic [6:0] rnd_opc();
    logic [6:0] o;
    case ($urandom % 5)
      0: o = OPC_R;
      1: o = OPC_LW;
      2: o = OPC_SW;
      3: o = OPC_BEQ;
      default: begin
        o = 7'($urandom);
        while (o == OPC_R || o == OPC_LW || o == OPC_SW || o == OPC_BEQ) o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  initial begin
    // Outputs are all zero while reset is held, even though the state is FETCH.
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", 32'(obs), 32'h0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(OPC_R,   1'b0, 0, 0);
    run_instr(OPC_LW,  1'b0, 0, 3);
    run_instr(OPC_BEQ, 1'b1, 0, 0);
    run_instr(OPC_BEQ, 1'b0, 0, 0);
    run_instr(7'b0010011, 1'b0, 0, 0);
    run_instr(OPC_SW,  1'b0, 0, TMO);
    run_instr(OPC_LW,  1'b0, TMO - 1, TMO - 1);
    run_instr(OPC_SW,  1'b0, TMO, 0);
    run_instr(OPC_LW,  1'b0, 0, TMO);

    // Reset in the middle of a stalled store.
    OPCode = OPC_SW;
    build(OPC_SW, 1'b0, 0, 0);
    plan = plan[0:2];
    push(1'b0, MWR | ADR, "memwr");
    push(1'b0, MWR | ADR, "memwr");
    play();
    mem_ready = 1'b0;
    #2;
    check_eq("pre_reset_memwr", 32'(obs), 32'(MWR | ADR));
    reset = 1'b1;
    #1;
    check_eq("async_reset_drop", 32'(obs), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_instr(OPC_R, 1'b0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      run_instr(rnd_opc(), rnd_bit(), rnd_wait(), rnd_wait());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
